// File: rtl/trng_ctrl.sv
// trng_ctrl: sequences the async_trng entropy source (reset, warm-up),
// runs a repetition-count health test on every consumed byte and shares
// healthy bytes between two requesters with round-robin arbitration.
// Ports:
//   i_clk, i_reset             clock, async active-high reset
//   i_start                    start/restart request (IDLE or FAULT only)
//   o_trng_reset               source reset, registered state decode
//   o_trng_init_val            source seed (constant INIT_VAL)
//   i_trng_dat, i_trng_valid   source byte and its valid flag
//   o_trng_read                combinational consume strobe to the source
//   i_req                      per-requester request level
//   o_gnt, o_dat               one-cycle one-hot grant with its byte
//   o_ready, o_fault           RUN indicator, health-test failure
module trng_ctrl #(
   parameter int         RST_CYCLES   = 4,
   parameter int         WARMUP_BYTES = 16,
   parameter int         REP_LIMIT    = 4,
   parameter logic [4:0] INIT_VAL     = 5'b01011
) (
   input  logic       i_clk,
   input  logic       i_reset,
   input  logic       i_start,
   output logic       o_trng_reset,
   output logic [4:0] o_trng_init_val,
   input  logic [7:0] i_trng_dat,
   input  logic       i_trng_valid,
   output logic       o_trng_read,
   input  logic [1:0] i_req,
   output logic [1:0] o_gnt,
   output logic [7:0] o_dat,
   output logic       o_ready,
   output logic       o_fault
);

   localparam int RW = $clog2(RST_CYCLES + 1);
   localparam int WW = $clog2(WARMUP_BYTES + 1);
   localparam int CW = $clog2(REP_LIMIT + 1);

   localparam logic [RW-1:0] RST_LAST  = RW'(RST_CYCLES - 1);
   localparam logic [WW-1:0] WARM_LAST = WW'(WARMUP_BYTES - 1);
   localparam logic [CW-1:0] REP_MAX   = CW'(REP_LIMIT);

   typedef enum logic [2:0] {
      S_IDLE,
      S_RESET,
      S_WARMUP,
      S_RUN,
      S_FAULT
   } state_t;

   state_t        state, state_nxt;
   logic [RW-1:0] rst_cnt;
   logic [WW-1:0] warm_cnt;
   logic [CW-1:0] rep_cnt, rep_nxt;
   logic [7:0]    last_byte;
   logic          ptr;

   logic [1:0] elig;
   logic       any_elig, win, consume, hit, grant;

   assign o_trng_init_val = INIT_VAL;
   assign o_ready         = (state == S_RUN);
   assign o_fault         = (state == S_FAULT);
   assign o_trng_read     = consume;

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) state <= S_IDLE;
      else         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      elig      = i_req & ~o_gnt;
      any_elig  = |elig;
      // tie goes to whoever did not win last; otherwise the lone requester
      win       = (elig == 2'b11) ? ~ptr : elig[1];
      consume   = i_trng_valid &
                  ((state == S_WARMUP) | ((state == S_RUN) & any_elig));
      // rep_cnt == 0 means no byte seen since the last RESET
      rep_nxt   = CW'(1);
      if ((rep_cnt != '0) && (i_trng_dat == last_byte))
         rep_nxt = (rep_cnt == REP_MAX) ? rep_cnt : rep_cnt + 1'b1;
      hit       = consume & (rep_nxt == REP_MAX);
      grant     = consume & (state == S_RUN) & ~hit;

      unique case (state)
         S_IDLE:   if (i_start) state_nxt = S_RESET;
         S_RESET:  if (rst_cnt == RST_LAST) state_nxt = S_WARMUP;
         S_WARMUP: begin
            if (hit)
               state_nxt = S_FAULT;
            else if (consume && (warm_cnt == WARM_LAST))
               state_nxt = S_RUN;
         end
         S_RUN:    if (hit) state_nxt = S_FAULT;
         S_FAULT:  if (i_start) state_nxt = S_RESET;
         default:  state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         o_trng_reset <= 1'b1;
         rst_cnt      <= '0;
         warm_cnt     <= '0;
         rep_cnt      <= '0;
         last_byte    <= 8'h00;
         ptr          <= 1'b1;
         o_gnt        <= 2'b00;
         o_dat        <= 8'h00;
      end else begin
         o_trng_reset <= (state_nxt == S_IDLE) ||
                         (state_nxt == S_RESET) ||
                         (state_nxt == S_FAULT);

         if (state == S_RESET) rst_cnt <= rst_cnt + 1'b1;
         else                  rst_cnt <= '0;

         if (state == S_RESET) begin
            warm_cnt <= '0;
            rep_cnt  <= '0;
         end else if (consume) begin
            rep_cnt   <= rep_nxt;
            last_byte <= i_trng_dat;
            if (state == S_WARMUP) warm_cnt <= warm_cnt + 1'b1;
         end

         o_gnt <= grant ? {win, ~win} : 2'b00;
         if (grant) begin
            o_dat <= i_trng_dat;
            ptr   <= win;
         end
      end
   end

endmodule

// File: tb/tb_trng_ctrl.sv
// tb_trng_ctrl: randomized and directed stimulus for trng_ctrl, checked
// against a behavioural model built from the block's rules.
module tb_trng_ctrl;

   localparam int RST  = 4;
   localparam int WARM = 16;
   localparam int REP  = 4;

   logic       i_clk = 1'b0;
   logic       i_reset, i_start;
   logic       o_trng_reset;
   logic [4:0] o_trng_init_val;
   logic [7:0] i_trng_dat;
   logic       i_trng_valid;
   logic       o_trng_read;
   logic [1:0] i_req;
   logic [1:0] o_gnt;
   logic [7:0] o_dat;
   logic       o_ready, o_fault;

   int vecs = 0;
   int errs = 0;

   // model: 0 idle, 1 source in reset, 2 warm-up, 3 run, 4 fault
   int         m_phase;
   int         m_rst_edges;
   int         m_warm;
   logic [7:0] m_hist[$];
   logic [1:0] m_gnt;
   logic [7:0] m_dat;
   int         m_last_win;

   trng_ctrl dut (
      .i_clk           (i_clk),
      .i_reset         (i_reset),
      .i_start         (i_start),
      .o_trng_reset    (o_trng_reset),
      .o_trng_init_val (o_trng_init_val),
      .i_trng_dat      (i_trng_dat),
      .i_trng_valid    (i_trng_valid),
      .o_trng_read     (o_trng_read),
      .i_req           (i_req),
      .o_gnt           (o_gnt),
      .o_dat           (o_dat),
      .o_ready         (o_ready),
      .o_fault         (o_fault)
   );

   always #5 i_clk = ~i_clk;

   task automatic model_reset();
      m_phase     = 0;
      m_rst_edges = 0;
      m_warm      = 0;
      m_hist.delete();
      m_gnt       = 2'b00;
      m_dat       = 8'h00;
      m_last_win  = 1;
   endtask

   task automatic model_start();
      m_phase     = 1;
      m_rst_edges = 0;
      m_warm      = 0;
      m_hist.delete();
   endtask

   // true when the last REP consumed bytes are all identical
   function automatic bit hist_bad();
      if (m_hist.size() < REP) return 1'b0;
      for (int i = 1; i < m_hist.size(); i++)
         if (m_hist[i] != m_hist[0]) return 1'b0;
      return 1'b1;
   endfunction

   // one clock: drive, check read strobe, clock, advance model, check outputs
   task automatic drive_cycle(input logic st, input logic v,
                              input logic [7:0] d, input logic [1:0] r);
      logic       exp_read;
      logic [1:0] el, eg;
      int         w;
      i_start      = st;
      i_trng_valid = v;
      i_trng_dat   = d;
      i_req        = r;
      el = r & ~m_gnt;
      exp_read = v && (m_phase == 2 || (m_phase == 3 && el != 2'b00));
      #1;
      vecs++;
      if (o_trng_read !== exp_read) begin
         errs++;
         $display("FAIL read: got %b exp %b t=%0t", o_trng_read, exp_read, $time);
      end
      @(posedge i_clk);
      #1;
      eg = 2'b00;
      case (m_phase)
         0: if (st) model_start();
         1: begin
            m_rst_edges++;
            if (m_rst_edges == RST) m_phase = 2;
         end
         2: if (exp_read) begin
            m_hist.push_back(d);
            if (m_hist.size() > REP) void'(m_hist.pop_front());
            if (hist_bad()) m_phase = 4;
            else begin
               m_warm++;
               if (m_warm == WARM) m_phase = 3;
            end
         end
         3: if (exp_read) begin
            m_hist.push_back(d);
            if (m_hist.size() > REP) void'(m_hist.pop_front());
            if (hist_bad()) m_phase = 4;
            else begin
               if (el == 2'b11) w = 1 - m_last_win;
               else             w = el[1] ? 1 : 0;
               eg = (w == 1) ? 2'b10 : 2'b01;
               m_dat = d;
               m_last_win = w;
            end
         end
         4: if (st) model_start();
         default: ;
      endcase
      m_gnt = eg;
      vecs += 5;
      if (o_gnt !== m_gnt) begin
         errs++;
         $display("FAIL gnt: got %b exp %b t=%0t", o_gnt, m_gnt, $time);
      end
      if (o_dat !== m_dat) begin
         errs++;
         $display("FAIL dat: got %h exp %h t=%0t", o_dat, m_dat, $time);
      end
      if (o_ready !== (m_phase == 3)) begin
         errs++;
         $display("FAIL ready: got %b exp %b t=%0t", o_ready, m_phase == 3, $time);
      end
      if (o_fault !== (m_phase == 4)) begin
         errs++;
         $display("FAIL fault: got %b exp %b t=%0t", o_fault, m_phase == 4, $time);
      end
      if (o_trng_reset !== (m_phase == 0 || m_phase == 1 || m_phase == 4)) begin
         errs++;
         $display("FAIL trng_reset: got %b phase %0d t=%0t", o_trng_reset, m_phase, $time);
      end
   endtask

   task automatic test_reset();
      int n;
      i_reset = 1'b1;
      i_start = 1'b0;
      i_trng_valid = 1'b0;
      i_trng_dat = 8'h00;
      i_req = 2'b00;
      model_reset();
      @(posedge i_clk);
      #1;
      vecs++;
      if ({o_trng_reset, o_trng_read, o_gnt, o_dat, o_ready, o_fault} !==
          {1'b1, 1'b0, 2'b00, 8'h00, 1'b0, 1'b0}) begin
         errs++;
         $display("FAIL reset_vals: got %b%b %b %h %b%b", o_trng_reset,
                  o_trng_read, o_gnt, o_dat, o_ready, o_fault);
      end
      vecs++;
      if (o_trng_init_val !== 5'b01011) begin
         errs++;
         $display("FAIL init_val: got %b exp 01011", o_trng_init_val);
      end
      i_reset = 1'b0;
      drive_cycle(1'b0, 1'b0, 8'h00, 2'b00);
      drive_cycle(1'b1, 1'b0, 8'h00, 2'b00);
      n = 0;
      while (o_trng_reset && n < 20) begin
         n++;
         drive_cycle(1'b0, 1'b0, 8'h00, 2'b00);
      end
      vecs++;
      if (n != RST) begin
         errs++;
         $display("FAIL reset_len: got %0d cycles exp %0d", n, RST);
      end
   endtask

   task automatic test_warmup_single();
      for (int i = 0; i < WARM; i++) begin
         drive_cycle(1'b0, 1'b1, 8'(i + 1), 2'b01);
         if (i == WARM - 2) begin
            vecs++;
            if (o_ready !== 1'b0) begin
               errs++;
               $display("FAIL ready_early: got %b exp 0", o_ready);
            end
         end
      end
      vecs++;
      if (o_ready !== 1'b1 || o_gnt !== 2'b00) begin
         errs++;
         $display("FAIL warm_end: got ready %b gnt %b exp 1 00", o_ready, o_gnt);
      end
      drive_cycle(1'b0, 1'b1, 8'h3C, 2'b01);
      vecs++;
      if (o_gnt !== 2'b01 || o_dat !== 8'h3C) begin
         errs++;
         $display("FAIL first_byte: got %b %h exp 01 3c", o_gnt, o_dat);
      end
      for (int i = 0; i < 10; i++)
         drive_cycle(1'b0, $urandom_range(0, 1), 8'(8'h80 + i), 2'b01);
   endtask

   task automatic test_round_robin();
      logic [1:0] prev;
      prev = m_gnt;
      for (int i = 0; i < 8; i++) begin
         drive_cycle(1'b0, 1'b1, 8'(8'hC0 + i * 3), 2'b11);
         vecs++;
         if (o_gnt === 2'b00 || o_gnt === prev) begin
            errs++;
            $display("FAIL rr_alt: got %b prev %b", o_gnt, prev);
         end
         prev = m_gnt;
      end
   endtask

   task automatic test_random();
      logic [7:0] d, p;
      p = 8'h00;
      for (int i = 0; i < 200; i++) begin
         d = 8'($urandom);
         if (d == p) d = d + 8'h01;
         p = d;
         drive_cycle(1'b0, 1'($urandom_range(0, 1)), d, 2'($urandom_range(0, 3)));
      end
   endtask

   task automatic test_health_fault();
      drive_cycle(1'b0, 1'b1, 8'h55, 2'b11);
      for (int i = 0; i < REP; i++) begin
         drive_cycle(1'b0, 1'b1, 8'hAA, 2'b11);
         if (i == REP - 2) begin
            vecs++;
            if (o_fault !== 1'b0 || o_gnt === 2'b00) begin
               errs++;
               $display("FAIL pre_fault: got fault %b gnt %b", o_fault, o_gnt);
            end
         end
      end
      vecs++;
      if (o_fault !== 1'b1 || o_gnt !== 2'b00 || o_trng_reset !== 1'b1 ||
          o_ready !== 1'b0) begin
         errs++;
         $display("FAIL fault_hit: got fault %b gnt %b rst %b ready %b",
                  o_fault, o_gnt, o_trng_reset, o_ready);
      end
      for (int i = 0; i < 3; i++) begin
         drive_cycle(1'b0, 1'b1, 8'hAA, 2'b11);
         vecs++;
         if (o_gnt !== 2'b00 || o_fault !== 1'b1) begin
            errs++;
            $display("FAIL fault_hold: got gnt %b fault %b", o_gnt, o_fault);
         end
      end
   endtask

   task automatic test_fault_recovery();
      int n;
      drive_cycle(1'b1, 1'b0, 8'h00, 2'b00);
      vecs++;
      if (o_fault !== 1'b0) begin
         errs++;
         $display("FAIL fault_clear: got %b exp 0", o_fault);
      end
      n = 0;
      while (o_trng_reset && n < 20) begin
         n++;
         drive_cycle(1'b0, 1'b0, 8'h00, 2'b00);
      end
      vecs++;
      if (n != RST) begin
         errs++;
         $display("FAIL rerst_len: got %0d exp %0d", n, RST);
      end
      for (int i = 0; i < WARM; i++)
         drive_cycle(1'b0, 1'b1, 8'(8'h40 + i), 2'b00);
      vecs++;
      if (o_ready !== 1'b1) begin
         errs++;
         $display("FAIL recover_ready: got %b exp 1", o_ready);
      end
   endtask

   task automatic test_async_reset();
      drive_cycle(1'b0, 1'b1, 8'h77, 2'b10);
      i_reset = 1'b1;
      #1;
      vecs++;
      if (o_gnt !== 2'b00 || o_dat !== 8'h00 || o_trng_reset !== 1'b1 ||
          o_ready !== 1'b0 || o_trng_read !== 1'b0) begin
         errs++;
         $display("FAIL async_rst: got gnt %b dat %h rst %b ready %b read %b",
                  o_gnt, o_dat, o_trng_reset, o_ready, o_trng_read);
      end
      model_reset();
      @(posedge i_clk);
      #1;
      i_reset = 1'b0;
      for (int i = 0; i < 4; i++) begin
         drive_cycle(1'b0, 1'b1, 8'(8'h20 + i), 2'b11);
         vecs++;
         if (o_gnt !== 2'b00) begin
            errs++;
            $display("FAIL post_rst_gnt: got %b exp 00", o_gnt);
         end
      end
   endtask

   initial begin
      test_reset();
      test_warmup_single();
      test_round_robin();
      test_random();
      test_health_fault();
      test_fault_recovery();
      test_async_reset();
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule
